div_share_ctrl: RTL and testbench

- Arbitrated controller that shares one iterative sign-magnitude divider between N requesters (ALU lanes).
- Accepts a request, captures the operands and runs a restoring division, one quotient bit per cycle.
- Returns result plus 4-bit status to the granted requester.
- Same arithmetic contract as the combinational division unit: sign = XOR of sign bits, magnitude = truncated quotient of magnitudes, divide-by-zero status 4'b1000.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_iter_core.sv | 60 ++++++
 rtl/div_share_ctrl.sv | 128 ++++++++++++
 tb/tb_div_share_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types, status codes and sign-magnitude field helpers for the shared
// iterative divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [3:0] STAT_OK   = 4'b0000;
  localparam logic [3:0] STAT_DIV0 = 4'b1000;

  // Operands arrive zero-extended to 32 bits; m is the operand width.
  function automatic logic sign_of(input logic [31:0] x, input int m);
    return x[m-1];
  endfunction

  function automatic logic [31:0] mag_of(input logic [31:0] x, input int m);
    return x & ((32'd1 << (m - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per clock, MSB
// first, starting on the edge after i_load.
module div_iter_core #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_dividend_mag,
  input  logic [W-1:0] i_divisor_mag,
  output logic [W-1:0] o_quot,
  output logic         o_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic [W:0]    trial;
  logic          take;
  logic [W-1:0]  rem_next;

  // The dividend is shifted out of quot_q while quotient bits shift in; trial
  // is the full-width partial remainder for the current step.
  always_comb begin
    trial    = {rem_q, quot_q[W-1]};
    take     = (trial >= {1'b0, div_q});
    rem_next = take ? (trial[W-1:0] - div_q) : trial[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rem_q    <= '0;
      quot_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (i_load) begin
      rem_q    <= '0;
      quot_q   <= i_dividend_mag;
      div_q    <= i_divisor_mag;
      cnt_q    <= CW'(W - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q  <= rem_next;
      quot_q <= {quot_q[W-2:0], take};
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign o_quot = quot_q;
  assign o_last = active_q && (cnt_q == '0);

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one iterative sign-magnitude divider between
// N requesters; returns quotient and status to the granted requester.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int M = 8,
  parameter int K = 8,
  parameter int N = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N-1:0]        i_req,
  input  logic [N-1:0][M-1:0] i_arg_A,
  input  logic [N-1:0][M-1:0] i_arg_B,
  output logic [N-1:0]        o_gnt,
  output logic [N-1:0]        o_done,
  output logic [K-1:0]        o_result,
  output logic [3:0]          o_status,
  output logic                o_busy
);

  localparam int MW = M - 1;
  localparam int PW = $clog2(N);

  if (K != M) begin : g_bad_width
    $error("div_share_ctrl: K must equal M");
  end
  if (N < 2 || N > 4) begin : g_bad_count
    $error("div_share_ctrl: N must be in 2..4");
  end

  state_t        state_q, state_d;
  logic [PW-1:0] last_q, owner_q, win;
  logic          any_req, capture, b_zero;
  logic          sign_q, div0_q;
  logic [K-1:0]  result_q, done_result;
  logic [3:0]    status_q, done_status;
  logic [M-1:0]  a_sel, b_sel;
  logic [MW-1:0] core_quot;
  logic          core_last;

  // Round-robin search starts one past the last served requester and wraps.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    win     = last_q;
    any_req = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_req && i_req[(int'(last_q) + k) % N]) begin
        any_req = 1'b1;
        win     = PW'((int'(last_q) + k) % N);
      end
    end
  end

  assign a_sel   = i_arg_A[win];
  assign b_sel   = i_arg_B[win];
  assign b_zero  = (MW'(mag_of(32'(b_sel), M)) == '0);
  assign capture = (state_q == IDLE) && any_req;

  div_iter_core #(.W(MW)) u_core (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_load         (capture && !b_zero),
    .i_dividend_mag (MW'(mag_of(32'(a_sel), M))),
    .i_divisor_mag  (MW'(mag_of(32'(b_sel), M))),
    .o_quot         (core_quot),
    .o_last         (core_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = b_zero ? DONE : CALC;
      CALC:    if (core_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture side: grant pulse, owner, pointer and result sign of the winner.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_gnt    <= '0;
      owner_q  <= '0;
      last_q   <= PW'(N - 1);
      sign_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      status_q <= STAT_OK;
    end else begin
      o_gnt <= '0;
      if (capture) begin
        o_gnt   <= N'(1) << win;
        owner_q <= win;
        last_q  <= win;
        sign_q  <= sign_of(32'(a_sel), M) ^ sign_of(32'(b_sel), M);
        div0_q  <= b_zero;
      end
      if (state_q == DONE) begin
        result_q <= done_result;
        status_q <= done_status;
      end
    end
  end

  assign done_result = div0_q ? '0 : {sign_q, core_quot};
  assign done_status = div0_q ? STAT_DIV0 : STAT_OK;

  // Result is presented live in DONE and held from the register afterwards.
  always_comb begin
    o_busy   = (state_q != IDLE);
    o_done   = '0;
    o_result = result_q;
    o_status = status_q;
    if (state_q == DONE) begin
      o_done[owner_q] = 1'b1;
      o_result        = done_result;
      o_status        = done_status;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: expected completions are queued when a
// request is driven and compared when o_done fires.
module tb_div_share_ctrl;
  import div_pkg::*;

  localparam int M = 8;
  localparam int K = 8;
  localparam int N = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req;
  logic [N-1:0][M-1:0] arg_a, arg_b;
  logic [N-1:0]        gnt, done;
  logic [K-1:0]        result;
  logic [3:0]          status;
  logic                busy;

  div_share_ctrl #(.M(M), .K(K), .N(N)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .o_gnt    (gnt),
    .o_done   (done),
    .o_result (result),
    .o_status (status),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [K-1:0] res;
    logic [3:0]   stat;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [N-1:0] mon_done;
  int checks = 0, failures = 0, cycle = 0, done_cnt = 0, last_done_cycle = 0;

  always @(posedge clk) cycle++;

  // Completion monitor: every o_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      done_cnt++;
      last_done_cycle = cycle;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected got done=%b result=%h status=%b expected no completion",
                 done, result, status);
      end else begin
        mon_e    = sb.pop_front();
        mon_done = N'(1) << mon_e.idx;
        if (done !== mon_done || result !== mon_e.res || status !== mon_e.stat) begin
          failures++;
          $display("FAIL done_check got done=%b result=%h status=%b expected done=%b result=%h status=%b",
                   done, result, status, mon_done, mon_e.res, mon_e.stat);
        end
      end
    end
  end

  task automatic wait_gnt(input int idx, input string name, output int gc);
    gc = -1000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt[idx]) begin
        gc = cycle;
        break;
      end
    end
    checks++;
    if (gc < 0) begin
      failures++;
      $display("FAIL %s_gnt_timeout got no o_gnt[%0d] expected one within 30 cycles", name, idx);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge clk);
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL %s_done_timeout got %0d completions expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic run_one(input int idx, input logic [M-1:0] a, input logic [M-1:0] b,
                         input logic [K-1:0] res, input logic [3:0] stat,
                         input int lat, input string name);
    int c_req, gc, n0;
    @(negedge clk);
    n0    = done_cnt;
    c_req = cycle;
    req[idx]   = 1'b1;
    arg_a[idx] = a;
    arg_b[idx] = b;
    sb.push_back('{idx, res, stat});
    wait_gnt(idx, name, gc);
    req[idx] = 1'b0;
    checks++;
    if (gc != c_req + 1) begin
      failures++;
      $display("FAIL %s_gnt_latency got cycle %0d expected %0d", name, gc, c_req + 1);
    end
    wait_done(n0 + 1, name);
    checks++;
    if (last_done_cycle - gc != lat) begin
      failures++;
      $display("FAIL %s_done_latency got %0d cycles after grant expected %0d",
               name, last_done_cycle - gc, lat);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    arg_a = '0;
    arg_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, done, result, status, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b done=%b result=%h status=%b busy=%b expected all zero",
               gnt, done, result, status, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    run_one(0, 8'h0F, 8'h83, 8'h85, STAT_OK, M - 1, "single");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_after got %b expected 0", busy);
    end
  endtask

  task automatic test_div_zero();
    run_one(1, 8'h05, 8'h00, 8'h00, STAT_DIV0, 0, "div0_pos");
    run_one(1, 8'h05, 8'h80, 8'h00, STAT_DIV0, 0, "div0_neg");
  endtask

  task automatic test_extremes();
    run_one(0, 8'h7F, 8'h01, 8'h7F, STAT_OK, M - 1, "max_by_one");
    run_one(1, 8'hFF, 8'hFF, 8'h01, STAT_OK, M - 1, "neg_max_self");
    run_one(0, 8'h03, 8'h85, 8'h80, STAT_OK, M - 1, "signed_zero");
  endtask

  task automatic test_round_robin();
    int           gc, prev, n0;
    logic [N-1:0] exp_g;
    pulse_reset();
    n0       = done_cnt;
    arg_a[0] = 8'h64;
    arg_a[1] = 8'h64;
    arg_b[0] = 8'h0A;
    arg_b[1] = 8'h0A;
    req      = '1;
    for (int g = 0; g < 4; g++) sb.push_back('{g % 2, 8'h0A, STAT_OK});
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      gc = -1000;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (gnt != '0) begin
          gc = cycle;
          break;
        end
      end
      exp_g = N'(1) << (g % 2);
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("FAIL rr_order grant %0d got o_gnt=%b expected %b", g, gnt, exp_g);
      end
      if (g > 0) begin
        checks++;
        if (gc - prev != M + 1) begin
          failures++;
          $display("FAIL rr_spacing grant %0d got %0d cycles expected %0d", g, gc - prev, M + 1);
        end
      end
      prev = gc;
    end
    req = '0;
    wait_done(n0 + 4, "rr");
  endtask

  task automatic test_reset_mid();
    int           gc, n0;
    logic [N-1:0] exp_g;
    @(negedge clk);
    n0       = done_cnt;
    arg_a[0] = 8'h0F;
    arg_b[0] = 8'h83;
    req[0]   = 1'b1;
    wait_gnt(0, "midrst", gc);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_calc got %b expected 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, done, result, status, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got gnt=%b done=%b result=%h status=%b busy=%b expected all zero",
               gnt, done, result, status, busy);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != n0) begin
      failures++;
      $display("FAIL midrst_no_done got %0d completions expected %0d", done_cnt, n0);
    end
    // Both request at once; the reset pointer must favour requester 0.
    arg_a[0] = 8'h0F;
    arg_b[0] = 8'h83;
    arg_a[1] = 8'h64;
    arg_b[1] = 8'h0A;
    req      = '1;
    sb.push_back('{0, 8'h85, STAT_OK});
    sb.push_back('{1, 8'h0A, STAT_OK});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    exp_g = N'(1);
    checks++;
    if (gnt !== exp_g) begin
      failures++;
      $display("FAIL midrst_ptr got o_gnt=%b expected %b", gnt, exp_g);
    end
    req[0] = 1'b0;
    wait_gnt(1, "midrst_second", gc);
    req[1] = 1'b0;
    wait_done(n0 + 2, "midrst");
  endtask

  task automatic test_back_to_back();
    int gc0, gc1, n0;
    @(negedge clk);
    n0       = done_cnt;
    arg_a[0] = 8'h7F;
    arg_b[0] = 8'h01;
    req[0]   = 1'b1;
    sb.push_back('{0, 8'h7F, STAT_OK});
    wait_gnt(0, "b2b_first", gc0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    // Requester 1 arrives mid-calculation while requester 0's inputs change.
    arg_a[0] = 8'h01;
    arg_b[0] = 8'h7F;
    arg_a[1] = 8'h64;
    arg_b[1] = 8'h0A;
    req[1]   = 1'b1;
    sb.push_back('{1, 8'h0A, STAT_OK});
    wait_gnt(1, "b2b_second", gc1);
    req[1] = 1'b0;
    // Grant pulse lands two cycles after the DONE cycle: IDLE arbitrates, then registers.
    checks++;
    if (gc1 - gc0 != M + 1) begin
      failures++;
      $display("FAIL b2b_spacing got %0d cycles expected %0d", gc1 - gc0, M + 1);
    end
    wait_done(n0 + 2, "b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_extremes();
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
